sr_tx_gen: RTL and testbench
============================

SR_TX_GEN -- requirements
Module: sr_tx_gen

Interface
REQ-001 Parameter DATA_W, default 32, frame width in bits; legal range 1..64.
REQ-002 Parameter CLK_DIV, default 1, clk cycles per SRCLK half-period; legal range 1..255.
REQ-003 Parameter RCLK_W, default 1, RCLK high width in clk cycles; legal range 1..15.
REQ-004 Parameter MSB_FIRST, default 1; 1 = data[DATA_W-1] shifted first, 0 = data[0] first.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  frame request; rising edge (start=1, previous sample 0) triggers a frame.
REQ-008 data  in  DATA_W  frame payload; sampled only on the trigger edge.
REQ-009 busy_nxt  in  1  downstream busy; level 1 clears finish.
REQ-010 busy  out  1  frame in progress.
REQ-011 SRCLK  out  1  shift clock to external shift register.
REQ-012 SER  out  1  serial data.
REQ-013 RCLK  out  1  storage-register latch pulse.
REQ-014 finish  out  1  frame complete, sticky until cleared.

Function
REQ-015 States SHALL be IDLE, SHIFT, LATCH (plus CLR per REQ-030); out-of-range parameters SHALL cause elaboration failure.
REQ-016 Edge k = clk edge at which start=1 and registered start=0 in IDLE; at edge k the block SHALL capture data into an internal shift register, set busy=1, clear finish, and enter SHIFT.
REQ-017 Start edges while busy=1 SHALL be ignored, not queued; data changes after edge k SHALL not affect the frame.
REQ-018 In SHIFT, bit i (i=0..DATA_W-1, in MSB_FIRST order) SHALL appear on SER from edge k+2*CLK_DIV*i, with SRCLK=0 for CLK_DIV cycles then SRCLK=1 for CLK_DIV cycles.
REQ-019 SER SHALL be stable across every SRCLK rising edge (changes only coincident with SRCLK falling or with SHIFT entry).
REQ-020 After DATA_W bits, at edge k+2*CLK_DIV*DATA_W, SRCLK=0, SER holds last bit, RCLK=1, state LATCH.
REQ-021 RCLK SHALL stay 1 for exactly RCLK_W cycles; at edge k+2*CLK_DIV*DATA_W+RCLK_W: RCLK=0, busy=0, finish=1, SER=0, state IDLE.
REQ-022 Frame latency (start edge to finish) SHALL be 2*CLK_DIV*DATA_W+RCLK_W cycles; defaults give RCLK at k+64, finish at k+65.
REQ-023 In IDLE, SRCLK=0, SER=0, RCLK=0.
REQ-024 finish SHALL clear on any edge where busy_nxt=1, except the edge that sets it (set wins); a new trigger edge also clears it.
REQ-025 Internal bit counter SHALL be sized ceil(log2(DATA_W+1)) and SHALL not wrap; CLK_DIV counter SHALL reload each half-period.
REQ-026 start held high across frame end SHALL NOT retrigger; a fresh 0->1 edge is required.

Reset
REQ-027 rst=1 at any edge, including mid-frame, SHALL force IDLE, busy=0, finish=0, SRCLK=0, SER=0, RCLK=0, all counters and registered start to 0.
REQ-028 start=1 at the first edge after rst deasserts SHALL count as a rising edge.
REQ-029 No asynchronous set/clear paths SHALL exist.

Configuration
REQ-030 With macro SR_TX_GEN_SRCLR_EN defined: output SRCLR_n (1 bit, reset 1) exists; edge k enters CLR with SRCLR_n=0 for exactly one cycle, SHIFT starts at k+1, and all REQ-018..022 timings shift by +1.
REQ-031 Without SR_TX_GEN_SRCLR_EN: no SRCLR_n port, no CLR state, timings exactly as REQ-018..022.

Verification
REQ-032 Defaults, data=32'hA5A5_0F0F, start pulse -> SER bits A5A50F0F MSB first on 32 SRCLK rises, RCLK high at k+64 only, finish=1 at k+65.
REQ-033 DATA_W=8, CLK_DIV=3, RCLK_W=2, MSB_FIRST=0, data=8'h81 -> SRCLK period 6 cycles, SER order 1,0,0,0,0,0,0,1, RCLK high k+48..k+49, finish at k+50.
REQ-034 Second start pulse at k+10 during frame, data changed -> frame unchanged, single RCLK pulse, finish at k+65.
REQ-035 rst asserted at k+20 -> next edge all outputs at reset values; new start at k+30 -> full clean frame.
REQ-036 busy_nxt held 1 at frame end -> finish=1 for one cycle then 0; busy_nxt=0 -> finish stays 1 until busy_nxt=1.
REQ-037 SR_TX_GEN_SRCLR_EN defined, defaults -> SRCLR_n=0 at cycle k only, RCLK at k+65, finish at k+66.

Source files
------------

// File: rtl/sr_tx_gen_if.sv
// sr_tx_gen_if: frame request / shift-register bus for sr_tx_gen.
// master drives the request side, slave is the transmitter.
interface sr_tx_gen_if #(
  parameter int DATA_W = 32
) ();
  logic              start;
  logic [DATA_W-1:0] data;
  logic              busy_nxt;
  logic              busy;
  logic              SRCLK;
  logic              SER;
  logic              RCLK;
  logic              finish;

  modport master (
    output start, data, busy_nxt,
    input  busy, SRCLK, SER, RCLK, finish
  );

  modport slave (
    input  start, data, busy_nxt,
    output busy, SRCLK, SER, RCLK, finish
  );
endinterface

// File: rtl/sr_tx_gen.sv
// sr_tx_gen: serialises a frame onto SER/SRCLK and latches it with RCLK.
// Define SR_TX_GEN_SRCLR_EN for a one-cycle SRCLR_n clear before shifting.
module sr_tx_gen #(
  parameter int DATA_W    = 32,
  parameter int CLK_DIV   = 1,
  parameter int RCLK_W    = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  sr_tx_gen_if.slave bus
`ifdef SR_TX_GEN_SRCLR_EN
  ,
  output logic       SRCLR_n
`endif
);

  if (DATA_W < 1 || DATA_W > 64) begin : g_bad_data_w
    $error("sr_tx_gen: DATA_W must be 1..64");
  end
  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("sr_tx_gen: CLK_DIV must be 1..255");
  end
  if (RCLK_W < 1 || RCLK_W > 15) begin : g_bad_rclk_w
    $error("sr_tx_gen: RCLK_W must be 1..15");
  end
  if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_msb
    $error("sr_tx_gen: MSB_FIRST must be 0 or 1");
  end

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST    = BW'(DATA_W - 1);
  localparam logic [7:0]    DIV_LD  = 8'(CLK_DIV - 1);
  localparam logic [3:0]    RCLK_LD = 4'(RCLK_W - 1);
  localparam bit            MSB     = (MSB_FIRST != 0);

`ifdef SR_TX_GEN_SRCLR_EN
  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_LATCH, S_CLR
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_LATCH
  } state_t;
`endif

  state_t state;
  state_t state_nxt;

  logic              start_q;
  logic [DATA_W-1:0] sreg;
  logic [7:0]        div_cnt;
  logic              phase;
  logic [BW-1:0]     bit_cnt;
  logic [3:0]        rclk_cnt;

  logic trig;
  logic half_end;
  logic last_bit;
  logic latch_end;
  logic ser_bit;

  assign trig      = bus.start && !start_q
                   && (state == S_IDLE);
  assign half_end  = (div_cnt == 8'd0);
  assign last_bit  = half_end && phase
                   && (bit_cnt == LAST);
  assign latch_end = (state == S_LATCH)
                   && (rclk_cnt == 4'd0);
  assign ser_bit   = MSB ? sreg[DATA_W-1]
                         : sreg[0];

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state: idle -> (clr) -> shift -> latch -> idle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (trig) begin
`ifdef SR_TX_GEN_SRCLR_EN
          state_nxt = S_CLR;
`else
          state_nxt = S_SHIFT;
`endif
        end
      end
`ifdef SR_TX_GEN_SRCLR_EN
      S_CLR:   state_nxt = S_SHIFT;
`endif
      S_SHIFT: if (last_bit) state_nxt = S_LATCH;
      S_LATCH: if (latch_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs decoded from state and SRCLK phase
  always_comb begin
    bus.busy  = (state != S_IDLE);
    bus.SRCLK = (state == S_SHIFT) && phase;
    bus.RCLK  = (state == S_LATCH);
    bus.SER   = ((state == S_SHIFT)
              || (state == S_LATCH)) && ser_bit;
`ifdef SR_TX_GEN_SRCLR_EN
    SRCLR_n   = (state != S_CLR);
`endif
  end

  // shift register, half-period divider, bit and latch counters
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= 1'b0;
      sreg     <= '0;
      div_cnt  <= '0;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      rclk_cnt <= '0;
    end else begin
      start_q <= bus.start;
      if (trig) begin
        sreg    <= bus.data;
        div_cnt <= DIV_LD;
        phase   <= 1'b0;
        bit_cnt <= '0;
      end else if (state == S_SHIFT) begin
        if (half_end) begin
          div_cnt <= DIV_LD;
          phase   <= ~phase;
          if (phase) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST)
              rclk_cnt <= RCLK_LD;
            else if (MSB)
              sreg <= sreg << 1;
            else
              sreg <= sreg >> 1;
          end
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
      end else if (state == S_LATCH
                   && rclk_cnt != 4'd0) begin
        rclk_cnt <= rclk_cnt - 1'b1;
      end
    end
  end

  // sticky finish: set at latch end, cleared by busy_nxt or a new frame
  always_ff @(posedge clk) begin
    if (rst)
      bus.finish <= 1'b0;
    else if (latch_end)
      bus.finish <= 1'b1;
    else if (trig || bus.busy_nxt)
      bus.finish <= 1'b0;
  end

endmodule

// File: tb/tb_sr_tx_gen.sv
// tb_sr_tx_gen: frame table on a default instance, hand sequences
// for reset, busy_nxt and an 8-bit LSB-first instance.
module tb_sr_tx_gen;

`ifdef SR_TX_GEN_SRCLR_EN
  localparam int OFS = 1;
  logic srclr_a;
  logic srclr_b;
`else
  localparam int OFS = 0;
`endif

  localparam int RCLK_A = 64 + OFS;
  localparam int FIN_A  = 65 + OFS;
  localparam int RCLK_B = 48 + OFS;
  localparam int FIN_B  = 50 + OFS;

  typedef struct {
    logic [31:0] data;
    logic        bn;
    int          re;
    bit          hold;
    logic        fin_end;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic qa[$];
  logic qb[$];
  int   rise_a;
  int   rise_b;
  logic srclk_pa;
  logic srclk_pb;
  logic exp_a;
  logic exp_b;

  sr_tx_gen_if #(.DATA_W(32)) ba ();
  sr_tx_gen_if #(.DATA_W(8))  bb ();

  sr_tx_gen u_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (ba)
`ifdef SR_TX_GEN_SRCLR_EN
    ,
    .SRCLR_n (srclr_a)
`endif
  );

  sr_tx_gen #(
    .DATA_W    (8),
    .CLK_DIV   (3),
    .RCLK_W    (2),
    .MSB_FIRST (0)
  ) u_b (
    .clk     (clk),
    .rst     (rst),
    .bus     (bb)
`ifdef SR_TX_GEN_SRCLR_EN
    ,
    .SRCLR_n (srclr_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(
    input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction

  // scoreboard A: each SRCLK rise pops the expected SER bit
  always @(negedge clk) begin
    if (ba.SRCLK === 1'b1 && srclk_pa === 1'b0) begin
      rise_a++;
      if (qa.size() == 0) begin
        chk("ser_a_extra_rise", 1, 0);
      end else begin
        exp_a = qa.pop_front();
        chk("ser_a", ba.SER, exp_a);
      end
    end
    srclk_pa = ba.SRCLK;
  end

  // scoreboard B
  always @(negedge clk) begin
    if (bb.SRCLK === 1'b1 && srclk_pb === 1'b0) begin
      rise_b++;
      if (qb.size() == 0) begin
        chk("ser_b_extra_rise", 1, 0);
      end else begin
        exp_b = qb.pop_front();
        chk("ser_b", bb.SER, exp_b);
      end
    end
    srclk_pb = bb.SRCLK;
  end

  task automatic push_a(input logic [31:0] d);
    rise_a = 0;
    for (int i = 31; i >= 0; i--) qa.push_back(d[i]);
  endtask

  task automatic launch_a(input vec_t v);
    @(negedge clk);
    ba.busy_nxt = v.bn;
    ba.data     = v.data;
    ba.start    = 1'b1;
    push_a(v.data);
  endtask

  task automatic watch_a(input vec_t v);
    int rat;
    int rn;
    int fat;
    rat = -1;
    rn  = 0;
    fat = -1;
    @(posedge clk);
    #1;
    if (!v.hold) ba.start = 1'b0;
    ba.data = ~v.data;
    for (int j = 0; j <= FIN_A + 1; j++) begin
      @(negedge clk);
      if (j == 0) begin
        chk("busy_at_k", ba.busy, 1);
        chk("finish_at_k", ba.finish, 0);
      end
`ifdef SR_TX_GEN_SRCLR_EN
      if (j == 0) chk("srclr_k", srclr_a, 0);
      if (j == 1) chk("srclr_k1", srclr_a, 1);
`endif
      if (ba.RCLK) begin
        if (rat < 0) rat = j;
        rn++;
      end
      if (ba.finish && fat < 0) fat = j;
      if (v.re > 0 && j == v.re - 1) begin
        ba.start = 1'b1;
        ba.data  = $urandom;
      end
      if (v.re > 0 && j == v.re) ba.start = 1'b0;
    end
    chk("rclk_at", rat, RCLK_A);
    chk("rclk_width", rn, 1);
    chk("finish_at", fat, FIN_A);
    chk("finish_after", ba.finish, v.fin_end);
    chk("busy_after", ba.busy, 0);
    chk("ser_after", ba.SER, 0);
    chk("srclk_rises", rise_a, 32);
    chk("queue_left", qa.size(), 0);
    if (v.hold) begin
      ba.start = 1'b0;
      @(negedge clk);
    end
  endtask

  vec_t tbl[5];
  vec_t v;
  int   r1;
  int   r2;
  int   rat;
  int   rn;
  int   fat;
  logic pb;

  initial begin
    checks = 0;
    errors = 0;
    rise_a = 0;
    rise_b = 0;
    srclk_pa = 1'b0;
    srclk_pb = 1'b0;
    tbl[0] = '{32'hA5A5_0F0F, 1'b0, -1, 1'b0, 1'b1};
    tbl[1] = '{32'hFFFF_0000, 1'b1, -1, 1'b0, 1'b0};
    tbl[2] = '{32'h8000_0001, 1'b0, 10, 1'b0, 1'b1};
    tbl[3] = '{32'h1234_5678, 1'b0, -1, 1'b1, 1'b1};
    tbl[4] = '{32'h0000_0000, 1'b1, -1, 1'b0, 1'b0};

    rst = 1'b1;
    ba.start = 1'b0;
    ba.data = '0;
    ba.busy_nxt = 1'b0;
    bb.start = 1'b0;
    bb.data = '0;
    bb.busy_nxt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", ba.busy, 0);
    chk("rst_finish", ba.finish, 0);
    chk("rst_srclk", ba.SRCLK, 0);
    chk("rst_ser", ba.SER, 0);
    chk("rst_rclk", ba.RCLK, 0);
    chk("rst_busy_b", bb.busy, 0);
`ifdef SR_TX_GEN_SRCLR_EN
    chk("rst_srclr", srclr_a, 1);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      launch_a(tbl[t]);
      watch_a(tbl[t]);
    end

    // reset mid-frame, then start on first edge after release
    v = '{32'hDEAD_BEEF, 1'b0, -1, 1'b0, 1'b1};
    launch_a(v);
    @(posedge clk);
    #1;
    ba.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", ba.busy, 0);
    chk("mid_rst_finish", ba.finish, 0);
    chk("mid_rst_srclk", ba.SRCLK, 0);
    chk("mid_rst_ser", ba.SER, 0);
    chk("mid_rst_rclk", ba.RCLK, 0);
    rst = 1'b0;
    qa.delete();
    v = '{32'hC3C3_5A5A, 1'b0, -1, 1'b0, 1'b1};
    ba.data  = v.data;
    ba.start = 1'b1;
    push_a(v.data);
    watch_a(v);

    // finish stays until busy_nxt pulses
    @(negedge clk);
    chk("finish_sticky", ba.finish, 1);
    ba.busy_nxt = 1'b1;
    @(negedge clk);
    chk("finish_cleared", ba.finish, 0);
    ba.busy_nxt = 1'b0;

    // 8-bit LSB-first instance, CLK_DIV=3, RCLK_W=2
    @(negedge clk);
    bb.data  = 8'h81;
    bb.start = 1'b1;
    rise_b = 0;
    for (int i = 0; i < 8; i++)
      qb.push_back(((8'h81 >> i) & 8'h01) != 0);
    @(posedge clk);
    #1;
    bb.start = 1'b0;
    bb.data  = 8'h00;
    r1 = -1;
    r2 = -1;
    rat = -1;
    rn = 0;
    fat = -1;
    pb = 1'b0;
    for (int j = 0; j <= FIN_B + 1; j++) begin
      @(negedge clk);
      if (bb.SRCLK && !pb) begin
        if (r1 < 0) r1 = j;
        else if (r2 < 0) r2 = j;
      end
      pb = bb.SRCLK;
      if (bb.RCLK) begin
        if (rat < 0) rat = j;
        rn++;
      end
      if (bb.finish && fat < 0) fat = j;
    end
    chk("b_first_rise", r1, 3 + OFS);
    chk("b_srclk_period", r2 - r1, 6);
    chk("b_rclk_at", rat, RCLK_B);
    chk("b_rclk_width", rn, 2);
    chk("b_finish_at", fat, FIN_B);
    chk("b_busy_after", bb.busy, 0);
    chk("b_rises", rise_b, 8);
    chk("b_queue_left", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
